tlb: RTL and testbench

- Fully associative, 8-entry Sv39 instruction/data TLB for an RV64 core with 32-bit physical addresses.
- Sits between the pipeline (req/resp) and the page-table walker (ptw port).
- Translates a 28-bit VPN to a 20-bit PPN in the same cycle and checks R/W/X/U permissions against the effective privilege.
- Refills from the PTW on a miss; flushes on io_ptw_invalidate.

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_if.sv | 112 +++++++++++
 rtl/tlb_perm_check.sv | 52 +++++
 rtl/tlb.sv | 177 +++++++++++++++++
 tb/tb_tlb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the 8-entry Sv39 TLB.
package tlb_pkg;

    localparam int TLB_ASID_W = 7;
    localparam int TLB_PPN_W  = 20;
    localparam int TLB_VPN_W  = 27;

    localparam logic [1:0] PRV_U   = 2'd0;
    localparam logic [1:0] PRV_S   = 2'd1;
    localparam logic [1:0] PRV_M   = 2'd3;
    localparam logic [4:0] VM_SV39 = 5'd9;

    typedef enum logic [1:0] {
        S_READY,
        S_REQUEST,
        S_WAIT,
        S_WAIT_INV
    } tlb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [TLB_ASID_W-1:0] asid;
        logic [TLB_VPN_W-1:0]  vpn;
        logic [TLB_PPN_W-1:0]  ppn;
        logic                  g;
        logic                  u;
        logic                  r;
        logic                  w;
        logic                  x;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_if.sv
// Pipeline request/response and page-table-walker signals of the TLB.
interface tlb_if;

    logic        io_req_ready;
    logic        io_req_valid;
    logic [27:0] io_req_bits_vpn;
    logic        io_req_bits_passthrough;
    logic        io_req_bits_instruction;
    logic        io_req_bits_store;

    logic        io_resp_miss;
    logic [19:0] io_resp_ppn;
    logic        io_resp_xcpt_ld;
    logic        io_resp_xcpt_st;
    logic        io_resp_xcpt_if;
    logic        io_resp_cacheable;

    logic        io_ptw_req_ready;
    logic        io_ptw_req_valid;
    logic [1:0]  io_ptw_req_bits_prv;
    logic        io_ptw_req_bits_pum;
    logic        io_ptw_req_bits_mxr;
    logic [26:0] io_ptw_req_bits_addr;
    logic        io_ptw_req_bits_store;
    logic        io_ptw_req_bits_fetch;

    logic        io_ptw_resp_valid;
    logic [15:0] io_ptw_resp_bits_pte_reserved_for_hardware;
    logic [37:0] io_ptw_resp_bits_pte_ppn;
    logic [1:0]  io_ptw_resp_bits_pte_reserved_for_software;
    logic        io_ptw_resp_bits_pte_d;
    logic        io_ptw_resp_bits_pte_a;
    logic        io_ptw_resp_bits_pte_g;
    logic        io_ptw_resp_bits_pte_u;
    logic        io_ptw_resp_bits_pte_x;
    logic        io_ptw_resp_bits_pte_w;
    logic        io_ptw_resp_bits_pte_r;
    logic        io_ptw_resp_bits_pte_v;

    logic [6:0]  io_ptw_ptbr_asid;
    logic [37:0] io_ptw_ptbr_ppn;
    logic        io_ptw_invalidate;

    logic        io_ptw_status_debug;
    logic [31:0] io_ptw_status_isa;
    logic [1:0]  io_ptw_status_prv;
    logic        io_ptw_status_sd;
    logic [30:0] io_ptw_status_zero3;
    logic        io_ptw_status_sd_rv32;
    logic [1:0]  io_ptw_status_zero2;
    logic [4:0]  io_ptw_status_vm;
    logic [3:0]  io_ptw_status_zero1;
    logic        io_ptw_status_mxr;
    logic        io_ptw_status_pum;
    logic        io_ptw_status_mprv;
    logic [1:0]  io_ptw_status_xs;
    logic [1:0]  io_ptw_status_fs;
    logic [1:0]  io_ptw_status_mpp;
    logic [1:0]  io_ptw_status_hpp;
    logic        io_ptw_status_spp;
    logic        io_ptw_status_mpie;
    logic        io_ptw_status_hpie;
    logic        io_ptw_status_spie;
    logic        io_ptw_status_upie;
    logic        io_ptw_status_mie;
    logic        io_ptw_status_hie;
    logic        io_ptw_status_sie;
    logic        io_ptw_status_uie;

    modport slave (
        output io_req_ready, io_resp_miss, io_resp_ppn, io_resp_xcpt_ld, io_resp_xcpt_st,
               io_resp_xcpt_if, io_resp_cacheable, io_ptw_req_valid, io_ptw_req_bits_prv,
               io_ptw_req_bits_pum, io_ptw_req_bits_mxr, io_ptw_req_bits_addr,
               io_ptw_req_bits_store, io_ptw_req_bits_fetch,
        input  io_req_valid, io_req_bits_vpn, io_req_bits_passthrough, io_req_bits_instruction,
               io_req_bits_store, io_ptw_req_ready, io_ptw_resp_valid,
               io_ptw_resp_bits_pte_reserved_for_hardware, io_ptw_resp_bits_pte_ppn,
               io_ptw_resp_bits_pte_reserved_for_software, io_ptw_resp_bits_pte_d,
               io_ptw_resp_bits_pte_a, io_ptw_resp_bits_pte_g, io_ptw_resp_bits_pte_u,
               io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_r,
               io_ptw_resp_bits_pte_v, io_ptw_ptbr_asid, io_ptw_ptbr_ppn, io_ptw_invalidate,
               io_ptw_status_debug, io_ptw_status_isa, io_ptw_status_prv, io_ptw_status_sd,
               io_ptw_status_zero3, io_ptw_status_sd_rv32, io_ptw_status_zero2,
               io_ptw_status_vm, io_ptw_status_zero1, io_ptw_status_mxr, io_ptw_status_pum,
               io_ptw_status_mprv, io_ptw_status_xs, io_ptw_status_fs, io_ptw_status_mpp,
               io_ptw_status_hpp, io_ptw_status_spp, io_ptw_status_mpie, io_ptw_status_hpie,
               io_ptw_status_spie, io_ptw_status_upie, io_ptw_status_mie, io_ptw_status_hie,
               io_ptw_status_sie, io_ptw_status_uie
    );

    modport master (
        input  io_req_ready, io_resp_miss, io_resp_ppn, io_resp_xcpt_ld, io_resp_xcpt_st,
               io_resp_xcpt_if, io_resp_cacheable, io_ptw_req_valid, io_ptw_req_bits_prv,
               io_ptw_req_bits_pum, io_ptw_req_bits_mxr, io_ptw_req_bits_addr,
               io_ptw_req_bits_store, io_ptw_req_bits_fetch,
        output io_req_valid, io_req_bits_vpn, io_req_bits_passthrough, io_req_bits_instruction,
               io_req_bits_store, io_ptw_req_ready, io_ptw_resp_valid,
               io_ptw_resp_bits_pte_reserved_for_hardware, io_ptw_resp_bits_pte_ppn,
               io_ptw_resp_bits_pte_reserved_for_software, io_ptw_resp_bits_pte_d,
               io_ptw_resp_bits_pte_a, io_ptw_resp_bits_pte_g, io_ptw_resp_bits_pte_u,
               io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_w, io_ptw_resp_bits_pte_r,
               io_ptw_resp_bits_pte_v, io_ptw_ptbr_asid, io_ptw_ptbr_ppn, io_ptw_invalidate,
               io_ptw_status_debug, io_ptw_status_isa, io_ptw_status_prv, io_ptw_status_sd,
               io_ptw_status_zero3, io_ptw_status_sd_rv32, io_ptw_status_zero2,
               io_ptw_status_vm, io_ptw_status_zero1, io_ptw_status_mxr, io_ptw_status_pum,
               io_ptw_status_mprv, io_ptw_status_xs, io_ptw_status_fs, io_ptw_status_mpp,
               io_ptw_status_hpp, io_ptw_status_spp, io_ptw_status_mpie, io_ptw_status_hpie,
               io_ptw_status_spie, io_ptw_status_upie, io_ptw_status_mie, io_ptw_status_hie,
               io_ptw_status_sie, io_ptw_status_uie
    );

endinterface

// File: rtl/tlb_perm_check.sv
// Combinational page-permission check producing load/store/fetch page faults.
module tlb_perm_check
    import tlb_pkg::*;
(
    input  logic       lookup_valid_i,
    input  logic       hit_i,
    input  logic       bad_va_i,
    input  logic [1:0] priv_i,
    input  logic       pum_i,
    input  logic       mxr_i,
    input  logic       store_i,
    input  logic       instruction_i,
    input  logic       u_i,
    input  logic       r_i,
    input  logic       w_i,
    input  logic       x_i,
    output logic       xcpt_ld_o,
    output logic       xcpt_st_o,
    output logic       xcpt_if_o
);

    logic can_read;
    logic can_write;
    logic can_exec;
    logic data_priv_ok;
    logic fetch_priv_ok;

    assign can_read  = r_i || (x_i && mxr_i);
    assign can_write = r_i && w_i;
    assign can_exec  = x_i;

    // Supervisor may touch user data only when PUM is clear, and never executes user pages.
    always_comb begin
        data_priv_ok  = 1'b1;
        fetch_priv_ok = 1'b1;
        if (priv_i == PRV_U) begin
            data_priv_ok  = u_i;
            fetch_priv_ok = u_i;
        end else if (priv_i == PRV_S) begin
            data_priv_ok  = !u_i || !pum_i;
            fetch_priv_ok = !u_i;
        end
    end

    assign xcpt_ld_o = lookup_valid_i && !store_i && !instruction_i &&
                       (bad_va_i || (hit_i && !(can_read && data_priv_ok)));
    assign xcpt_st_o = lookup_valid_i && store_i && !instruction_i &&
                       (bad_va_i || (hit_i && !(can_write && data_priv_ok)));
    assign xcpt_if_o = lookup_valid_i && instruction_i &&
                       (bad_va_i || (hit_i && !(can_exec && fetch_priv_ok)));

endmodule

// File: rtl/tlb.sv
// Fully associative Sv39 TLB: same-cycle lookup, PTW refill FSM and SFENCE flush.
module tlb
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = 8,
    parameter int ASID_W    = TLB_ASID_W,
    parameter int PPN_W     = TLB_PPN_W
) (
    input  logic clock,
    input  logic reset,
    tlb_if.slave io
);

    localparam int IDX_W = $clog2(N_ENTRIES);

    tlb_state_e            state_q;
    logic                  ptw_req_valid_q;
    logic [IDX_W-1:0]      rr_q;
    logic [TLB_VPN_W-1:0]  vpn_q;
    logic                  store_q;
    logic                  instr_q;
    logic [1:0]            priv_q;
    tlb_entry_t            entries_q [N_ENTRIES];

    logic [1:0]            priv;
    logic                  vm_en;
    logic                  bad_va;
    logic                  hit;
    logic                  lookup_hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      victim;
    logic                  found_free;
    tlb_entry_t            hit_entry;
    logic [ASID_W-1:0]     cur_asid;
    logic [PPN_W-1:0]      resp_ppn;
    logic                  unused_sig;

    assign cur_asid = io.io_ptw_ptbr_asid;
    assign priv     = (io.io_ptw_status_mprv && !io.io_req_bits_instruction) ?
                      io.io_ptw_status_mpp : io.io_ptw_status_prv;
    assign vm_en    = (io.io_ptw_status_vm != 5'd0) && (priv != PRV_M) &&
                      !io.io_req_bits_passthrough;
    assign bad_va   = io.io_req_bits_vpn[27] ^ io.io_req_bits_vpn[26];

    // First matching entry wins; global entries ignore the ASID.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!hit && entries_q[i].valid &&
                entries_q[i].vpn == io.io_req_bits_vpn[TLB_VPN_W-1:0] &&
                (entries_q[i].g || entries_q[i].asid == cur_asid)) begin
                hit     = 1'b1;
                hit_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        victim     = rr_q;
        found_free = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!found_free && !entries_q[i].valid) begin
                found_free = 1'b1;
                victim     = i[IDX_W-1:0];
            end
        end
    end

    assign hit_entry  = entries_q[hit_idx];
    // A refill in flight hides all hits so the pipeline replays once it lands.
    assign lookup_hit = hit && (state_q == S_READY);
    assign resp_ppn   = vm_en ? (lookup_hit ? hit_entry.ppn : '0)
                              : io.io_req_bits_vpn[PPN_W-1:0];

    assign io.io_req_ready      = (state_q == S_READY);
    assign io.io_resp_miss      = vm_en && !bad_va && !lookup_hit;
    assign io.io_resp_ppn       = resp_ppn;
    assign io.io_resp_cacheable = resp_ppn[PPN_W-1];

    assign io.io_ptw_req_valid      = ptw_req_valid_q;
    assign io.io_ptw_req_bits_prv   = priv_q;
    assign io.io_ptw_req_bits_pum   = io.io_ptw_status_pum;
    assign io.io_ptw_req_bits_mxr   = io.io_ptw_status_mxr;
    assign io.io_ptw_req_bits_addr  = vpn_q;
    assign io.io_ptw_req_bits_store = store_q;
    assign io.io_ptw_req_bits_fetch = instr_q;

    tlb_perm_check u_perm (
        .lookup_valid_i (io.io_req_valid && vm_en),
        .hit_i          (lookup_hit),
        .bad_va_i       (bad_va),
        .priv_i         (priv),
        .pum_i          (io.io_ptw_status_pum),
        .mxr_i          (io.io_ptw_status_mxr),
        .store_i        (io.io_req_bits_store),
        .instruction_i  (io.io_req_bits_instruction),
        .u_i            (hit_entry.u),
        .r_i            (hit_entry.r),
        .w_i            (hit_entry.w),
        .x_i            (hit_entry.x),
        .xcpt_ld_o      (io.io_resp_xcpt_ld),
        .xcpt_st_o      (io.io_resp_xcpt_st),
        .xcpt_if_o      (io.io_resp_xcpt_if)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_READY;
            ptw_req_valid_q <= 1'b0;
            rr_q            <= '0;
            for (int i = 0; i < N_ENTRIES; i++) entries_q[i].valid <= 1'b0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (!io.io_ptw_invalidate && io.io_req_valid && vm_en && !hit && !bad_va) begin
                        vpn_q           <= io.io_req_bits_vpn[TLB_VPN_W-1:0];
                        store_q         <= io.io_req_bits_store;
                        instr_q         <= io.io_req_bits_instruction;
                        priv_q          <= priv;
                        ptw_req_valid_q <= 1'b1;
                        state_q         <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (io.io_ptw_invalidate || io.io_ptw_req_ready) begin
                        ptw_req_valid_q <= 1'b0;
                        state_q         <= io.io_ptw_invalidate ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io.io_ptw_resp_valid) begin
                        state_q <= S_READY;
                        if (!io.io_ptw_invalidate) begin
                            entries_q[victim] <= '{
                                valid: io.io_ptw_resp_bits_pte_v &&
                                       (io.io_ptw_resp_bits_pte_r || io.io_ptw_resp_bits_pte_x),
                                asid:  cur_asid,
                                vpn:   vpn_q,
                                ppn:   io.io_ptw_resp_bits_pte_ppn[PPN_W-1:0],
                                g:     io.io_ptw_resp_bits_pte_g,
                                u:     io.io_ptw_resp_bits_pte_u,
                                r:     io.io_ptw_resp_bits_pte_r,
                                w:     io.io_ptw_resp_bits_pte_w,
                                x:     io.io_ptw_resp_bits_pte_x
                            };
                            rr_q <= rr_q + 1'b1;
                        end
                    end else if (io.io_ptw_invalidate) begin
                        state_q <= S_WAIT_INV;
                    end
                end
                S_WAIT_INV: begin
                    if (io.io_ptw_resp_valid) state_q <= S_READY;
                end
                default: state_q <= S_READY;
            endcase
            // Flush overrides any refill landing in the same cycle.
            if (io.io_ptw_invalidate) begin
                for (int i = 0; i < N_ENTRIES; i++) entries_q[i].valid <= 1'b0;
            end
        end
    end

    assign unused_sig = ^{io.io_ptw_resp_bits_pte_reserved_for_hardware,
                          io.io_ptw_resp_bits_pte_ppn[37:PPN_W],
                          io.io_ptw_resp_bits_pte_reserved_for_software,
                          io.io_ptw_resp_bits_pte_d, io.io_ptw_resp_bits_pte_a,
                          io.io_ptw_ptbr_ppn, io.io_ptw_status_debug, io.io_ptw_status_isa,
                          io.io_ptw_status_sd, io.io_ptw_status_zero3, io.io_ptw_status_sd_rv32,
                          io.io_ptw_status_zero2, io.io_ptw_status_zero1, io.io_ptw_status_xs,
                          io.io_ptw_status_fs, io.io_ptw_status_hpp, io.io_ptw_status_spp,
                          io.io_ptw_status_mpie, io.io_ptw_status_hpie, io.io_ptw_status_spie,
                          io.io_ptw_status_upie, io.io_ptw_status_mie, io.io_ptw_status_hie,
                          io.io_ptw_status_sie, io.io_ptw_status_uie, found_free};

endmodule

// File: tb/tb_tlb.sv
// Directed bench for the Sv39 TLB: lookup, refill, permissions, flush, ASID and replacement.
module tb_tlb;

    localparam logic [5:0] F_V = 6'h01, F_R = 6'h02, F_W = 6'h04,
                           F_X = 6'h08, F_U = 6'h10, F_G = 6'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    tlb_if bus ();

    tlb dut (.clock(clk), .reset(rst), .io(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [27:0] vpn, input logic st, input logic ins);
        bus.io_req_bits_passthrough = 1'b0;
        bus.io_req_bits_vpn         = vpn;
        bus.io_req_bits_store       = st;
        bus.io_req_bits_instruction = ins;
        bus.io_req_valid            = 1'b1;
        #1;
    endtask

    task automatic idle();
        bus.io_req_valid            = 1'b0;
        bus.io_req_bits_store       = 1'b0;
        bus.io_req_bits_instruction = 1'b0;
        bus.io_req_bits_passthrough = 1'b0;
    endtask

    task automatic set_pte(input logic [19:0] ppn, input logic [5:0] f);
        bus.io_ptw_resp_bits_pte_ppn = {18'd0, ppn};
        bus.io_ptw_resp_bits_pte_v   = f[0];
        bus.io_ptw_resp_bits_pte_r   = f[1];
        bus.io_ptw_resp_bits_pte_w   = f[2];
        bus.io_ptw_resp_bits_pte_x   = f[3];
        bus.io_ptw_resp_bits_pte_u   = f[4];
        bus.io_ptw_resp_bits_pte_g   = f[5];
    endtask

    task automatic refill(input string tag, input logic [27:0] vpn, input logic [19:0] ppn,
                          input logic [5:0] f);
        lookup(vpn, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 0; k < 8 && !bus.io_ptw_req_valid; k++) step();
        check({tag, "_preq"}, bus.io_ptw_req_valid, 1);
        check({tag, "_addr"}, bus.io_ptw_req_bits_addr, vpn[26:0]);
        bus.io_ptw_req_ready = 1'b1;
        step();
        bus.io_ptw_req_ready = 1'b0;
        set_pte(ppn, f);
        bus.io_ptw_resp_valid = 1'b1;
        step();
        bus.io_ptw_resp_valid = 1'b0;
    endtask

    initial begin
        idle();
        bus.io_req_bits_vpn = '0;
        bus.io_ptw_req_ready = 1'b0;
        bus.io_ptw_resp_valid = 1'b0;
        bus.io_ptw_resp_bits_pte_reserved_for_hardware = '0;
        bus.io_ptw_resp_bits_pte_reserved_for_software = '0;
        bus.io_ptw_resp_bits_pte_d = 1'b0;
        bus.io_ptw_resp_bits_pte_a = 1'b0;
        set_pte(20'd0, 6'd0);
        bus.io_ptw_ptbr_asid = 7'd4;
        bus.io_ptw_ptbr_ppn = '0;
        bus.io_ptw_invalidate = 1'b0;
        bus.io_ptw_status_debug = 1'b0;  bus.io_ptw_status_isa = '0;
        bus.io_ptw_status_prv = 2'd0;    bus.io_ptw_status_sd = 1'b0;
        bus.io_ptw_status_zero3 = '0;    bus.io_ptw_status_sd_rv32 = 1'b0;
        bus.io_ptw_status_zero2 = '0;    bus.io_ptw_status_vm = 5'd9;
        bus.io_ptw_status_zero1 = '0;    bus.io_ptw_status_mxr = 1'b0;
        bus.io_ptw_status_pum = 1'b0;    bus.io_ptw_status_mprv = 1'b0;
        bus.io_ptw_status_xs = '0;       bus.io_ptw_status_fs = '0;
        bus.io_ptw_status_mpp = 2'd0;    bus.io_ptw_status_hpp = '0;
        bus.io_ptw_status_spp = 1'b0;    bus.io_ptw_status_mpie = 1'b0;
        bus.io_ptw_status_hpie = 1'b0;   bus.io_ptw_status_spie = 1'b0;
        bus.io_ptw_status_upie = 1'b0;   bus.io_ptw_status_mie = 1'b0;
        bus.io_ptw_status_hie = 1'b0;    bus.io_ptw_status_sie = 1'b0;
        bus.io_ptw_status_uie = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", bus.io_req_ready, 1);
        check("rst_preq", bus.io_ptw_req_valid, 0);

        // Test 1: miss, refill, then hit
        lookup(28'd1, 1'b0, 1'b0);
        check("t1_miss", bus.io_resp_miss, 1);
        idle();
        refill("t1", 28'd1, 20'h02000, F_V | F_U | F_R | F_W | F_X);
        lookup(28'd1, 1'b0, 1'b0);
        check("t1_hit_miss", bus.io_resp_miss, 0);
        check("t1_ppn", bus.io_resp_ppn, 32'h02000);
        check("t1_xld", bus.io_resp_xcpt_ld, 0);
        check("t1_cache", bus.io_resp_cacheable, 0);
        idle();

        // Test 2: passthrough
        lookup(28'd1, 1'b0, 1'b0);
        bus.io_req_bits_passthrough = 1'b1;
        #1;
        check("t2_ppn", bus.io_resp_ppn, 32'h00001);
        check("t2_miss", bus.io_resp_miss, 0);
        step();
        check("t2_nopreq", bus.io_ptw_req_valid, 0);
        bus.io_req_bits_vpn = 28'h0080000;
        #1;
        check("t2_cache", bus.io_resp_cacheable, 1);
        idle();

        // Test 3: permissions on an execute-only user page
        refill("t3", 28'd2, 20'h02001, F_V | F_W | F_X | F_U);
        bus.io_ptw_status_mxr = 1'b1;
        lookup(28'd2, 1'b0, 1'b0);
        check("t3_ppn", bus.io_resp_ppn, 32'h02001);
        check("t3_xld_mxr", bus.io_resp_xcpt_ld, 0);
        bus.io_ptw_status_mxr = 1'b0;
        #1;
        check("t3_xld_nomxr", bus.io_resp_xcpt_ld, 1);
        lookup(28'd2, 1'b1, 1'b0);
        check("t3_xst", bus.io_resp_xcpt_st, 1);
        lookup(28'd2, 1'b0, 1'b1);
        check("t3_xif_u", bus.io_resp_xcpt_if, 0);
        bus.io_ptw_status_prv = 2'd1;
        #1;
        check("t3_xif_s", bus.io_resp_xcpt_if, 1);
        bus.io_ptw_status_mxr = 1'b1;
        lookup(28'd2, 1'b0, 1'b0);
        check("t3_s_nopum", bus.io_resp_xcpt_ld, 0);
        bus.io_ptw_status_pum = 1'b1;
        #1;
        check("t3_s_pum", bus.io_resp_xcpt_ld, 1);
        bus.io_ptw_status_prv = 2'd0;
        bus.io_ptw_status_pum = 1'b0;
        bus.io_ptw_status_mxr = 1'b0;
        idle();

        // Test 4: non-canonical address
        lookup(28'h8000001, 1'b0, 1'b0);
        check("t4_xld", bus.io_resp_xcpt_ld, 1);
        check("t4_miss", bus.io_resp_miss, 0);
        step();
        check("t4_nopreq", bus.io_ptw_req_valid, 0);
        idle();

        // Test 5: flush in READY and during WAIT
        refill("t5", 28'd3, 20'h00003, F_V | F_U | F_R);
        lookup(28'd3, 1'b0, 1'b0);
        check("t5_hit", bus.io_resp_miss, 0);
        idle();
        bus.io_ptw_invalidate = 1'b1;
        step();
        bus.io_ptw_invalidate = 1'b0;
        lookup(28'd3, 1'b0, 1'b0);
        check("t5_flushed", bus.io_resp_miss, 1);
        step();
        idle();
        bus.io_ptw_req_ready = 1'b1;
        step();
        bus.io_ptw_req_ready = 1'b0;
        bus.io_ptw_invalidate = 1'b1;
        step();
        bus.io_ptw_invalidate = 1'b0;
        check("t5_inv_busy", bus.io_req_ready, 0);
        set_pte(20'h00003, F_V | F_U | F_R);
        bus.io_ptw_resp_valid = 1'b1;
        step();
        bus.io_ptw_resp_valid = 1'b0;
        check("t5_inv_ready", bus.io_req_ready, 1);
        lookup(28'd3, 1'b0, 1'b0);
        check("t5_dropped", bus.io_resp_miss, 1);
        idle();

        // Test 6: ASID tagging, global pages, round-robin eviction
        refill("t6a", 28'd5, 20'h00005, F_V | F_U | F_R);
        lookup(28'd5, 1'b0, 1'b0);
        check("t6_asid_hit", bus.io_resp_miss, 0);
        bus.io_ptw_ptbr_asid = 7'd5;
        #1;
        check("t6_asid_miss", bus.io_resp_miss, 1);
        idle();
        refill("t6g", 28'd6, 20'h00006, F_V | F_U | F_R | F_G);
        bus.io_ptw_ptbr_asid = 7'd4;
        lookup(28'd6, 1'b0, 1'b0);
        check("t6_g_hit4", bus.io_resp_miss, 0);
        check("t6_g_ppn", bus.io_resp_ppn, 32'h00006);
        bus.io_ptw_ptbr_asid = 7'h7f;
        #1;
        check("t6_g_hit7f", bus.io_resp_miss, 0);
        idle();
        bus.io_ptw_ptbr_asid = 7'd4;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            refill("t6rr", 28'h10 + 28'(i), 20'h00100 + 20'(i), F_V | F_U | F_R);
        end
        lookup(28'h10, 1'b0, 1'b0);
        check("t6_evicted", bus.io_resp_miss, 1);
        lookup(28'h11, 1'b0, 1'b0);
        check("t6_kept_ppn", bus.io_resp_ppn, 32'h00101);
        lookup(28'h18, 1'b0, 1'b0);
        check("t6_new_miss", bus.io_resp_miss, 0);
        check("t6_new_ppn", bus.io_resp_ppn, 32'h00108);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
